dac_update_sched: RTL and testbench



---
 rtl/dac_update_sched.sv | 134 +++++++++++++
 tb/tb_dac_update_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_sched.sv
// Round-robin update scheduler in front of the DAC7554 SPI shifter: shadow registers, pending tracking, word build.
// Optional: define DAC_SCHED_LDAC_SYNC_EN for load-only commands plus a shared LDAC strobe after each burst.
module dac_update_sched #(
  parameter int XFER_CYCLES = 68,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_ch,
  input  logic [11:0] wr_data,
  output logic [3:0]  pending,
  output logic        busy,
  output logic        upd_done,
  output logic        dac_ctrl,
  output logic [15:0] dac_dato,
  output logic        ldac_n,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_XFER   = 3'd2,
`ifdef DAC_SCHED_LDAC_SYNC_EN
    S_GAP    = 3'd3,
    S_STROBE = 3'd4
`else
    S_GAP    = 3'd3
`endif
  } state_t;

  localparam logic [7:0] XFER_LAST = 8'(XFER_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
`ifdef DAC_SCHED_LDAC_SYNC_EN
  localparam logic [1:0] CMD = 2'b00;
`else
  localparam logic [1:0] CMD = 2'b10;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [11:0] r_shadow [4];
  logic [3:0]  r_pending;
  logic [1:0]  r_rr;
  logic [15:0] r_dato;
  logic        r_upd_done;
  logic [1:0]  w_sel;
  logic [1:0]  w_cand;
  logic        w_found;
  logic [3:0]  w_clr;
  logic [3:0]  w_set;

  // First pending channel after the last one served, wrapping; i=4 lands back on r_rr.
  always_comb begin
    w_sel   = r_rr;
    w_cand  = r_rr;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_rr + 2'(i);
      if (!w_found && r_pending[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_clr = 4'b0000;
    w_set = 4'b0000;
    if (r_state == S_LOAD) w_clr = 4'b0001 << w_sel;
    if (wr_en)             w_set = 4'b0001 << wr_ch;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|r_pending) w_next = S_LOAD;
      S_LOAD: w_next = S_XFER;
      S_XFER: if (r_cnt == XFER_LAST) w_next = S_GAP;
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (|r_pending) w_next = S_LOAD;
`ifdef DAC_SCHED_LDAC_SYNC_EN
          else            w_next = S_STROBE;
`else
          else            w_next = S_IDLE;
`endif
        end
      end
`ifdef DAC_SCHED_LDAC_SYNC_EN
      S_STROBE: if (r_cnt == 8'd1) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_pending  <= 4'b0000;
      r_rr       <= 2'd3;
      r_dato     <= 16'h0000;
      r_upd_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= 12'h000;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      r_upd_done <= (r_state == S_XFER) && (w_next == S_GAP);
      // A write landing on the channel being loaded keeps it pending (set wins over clear).
      r_pending  <= (r_pending & ~w_clr) | w_set;
      if (wr_en) r_shadow[wr_ch] <= wr_data;
      if (r_state == S_LOAD) begin
        r_rr   <= w_sel;
        r_dato <= {CMD, w_sel, r_shadow[w_sel]};
      end
    end
  end

  assign pending   = r_pending;
  assign busy      = (r_state != S_IDLE);
  assign upd_done  = r_upd_done;
  assign dac_ctrl  = (r_state != S_XFER);
  assign dac_dato  = r_dato;
  assign dbg_state = r_state;
`ifdef DAC_SCHED_LDAC_SYNC_EN
  assign ldac_n    = (r_state != S_STROBE);
`else
  assign ldac_n    = 1'b1;
`endif

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed bench for dac_update_sched: word order, timing windows, coalescing, write-vs-load race, reset abort.
module tb_dac_update_sched;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_XFER   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
`ifdef DAC_SCHED_LDAC_SYNC_EN
  localparam logic [1:0] CMD = 2'b00;
  localparam int STROBE_LEN = 2;
`else
  localparam logic [1:0] CMD = 2'b10;
  localparam int STROBE_LEN = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [11:0] wr_data = 12'h000;
  logic [3:0]  pending;
  logic        busy;
  logic        upd_done;
  logic        dac_ctrl;
  logic [15:0] dac_dato;
  logic        ldac_n;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int ldac_lows = 0;

  dac_update_sched dut (
    .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .pending(pending), .busy(busy), .upd_done(upd_done), .dac_ctrl(dac_ctrl),
    .dac_dato(dac_dato), .ldac_n(ldac_n), .dbg_state(dbg_state)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (ldac_n === 1'b0) ldac_lows++;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [11:0] data);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Follows one word from its first low dac_ctrl cycle through GAP (and STROBE, if any).
  task automatic run_word(output logic [15:0] word, output int low, output int gap,
                          output int done, output int strobe, output logic stable,
                          output logic timeout);
    int w;
    word = 16'h0000; low = 0; gap = 0; done = 0; strobe = 0; stable = 1'b1; timeout = 1'b0;
    w = 0;
    while (dac_ctrl !== 1'b0 && w < 10) begin tick(); w++; end
    if (dac_ctrl !== 1'b0) timeout = 1'b1;
    if (!timeout) begin
      word = dac_dato;
      while (dac_ctrl === 1'b0 && low < 200) begin
        low++;
        if (dac_dato !== word) stable = 1'b0;
        if (upd_done === 1'b1) done++;
        tick();
      end
      while (dbg_state === ST_GAP && gap < 20) begin
        gap++;
        if (upd_done === 1'b1) done++;
        tick();
      end
      while (dbg_state === ST_STROBE && strobe < 20) begin strobe++; tick(); end
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] exp_word,
                            input int exp_low, input logic last);
    logic [15:0] word;
    int low, gap, done, strobe;
    logic stable, timeout;
    run_word(word, low, gap, done, strobe, stable, timeout);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_word"}, 32'(word), 32'(exp_word));
    chk({tag, "_low"}, low, exp_low);
    chk({tag, "_stable"}, 32'(stable), 32'd1);
    chk({tag, "_gap"}, gap, 4);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_strobe"}, strobe, last ? STROBE_LEN : 0);
  endtask

  initial begin : stim
    int lows_snap, lo_cnt, done_cnt, busy_cnt;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upd_done", 32'(upd_done), 32'd0);
    chk("rst_dac_ctrl", 32'(dac_ctrl), 32'd1);
    chk("rst_dato", 32'(dac_dato), 32'h0);
    chk("rst_ldac", 32'(ldac_n), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single idle write: latency and one word
    write(2'd2, 12'hABC);
    chk("t1_e0_pending", 32'(pending), 32'h4);
    chk("t1_e0_ctrl", 32'(dac_ctrl), 32'd1);
    tick();
    chk("t1_e1_state", 32'(dbg_state), 32'(ST_LOAD));
    chk("t1_e1_ctrl", 32'(dac_ctrl), 32'd1);
    tick();
    chk("t1_e2_ctrl", 32'(dac_ctrl), 32'd0);
    chk("t1_e2_dato", 32'(dac_dato), 32'({CMD, 2'd2, 12'hABC}));
    chk("t1_e2_pending", 32'(pending), 32'h0);
    check_word("t1", {CMD, 2'd2, 12'hABC}, 68, 1'b1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Three channels queued on consecutive cycles: round-robin order
    write(2'd0, 12'h111);
    write(2'd1, 12'h222);
    write(2'd3, 12'h333);
    check_word("t2_ch0", {CMD, 2'd0, 12'h111}, 68, 1'b0);
    check_word("t2_ch1", {CMD, 2'd1, 12'h222}, 68, 1'b0);
    check_word("t2_ch3", {CMD, 2'd3, 12'h333}, 68, 1'b1);
    chk("t2_pending", 32'(pending), 32'h0);

    // Coalescing writes during XFER of the same channel
    write(2'd1, 12'h444);
    tick(); tick();
    chk("t3_dato0", 32'(dac_dato), 32'({CMD, 2'd1, 12'h444}));
    write(2'd1, 12'h555);
    write(2'd1, 12'h555);
    write(2'd1, 12'h666);
    chk("t3_dato_held", 32'(dac_dato), 32'({CMD, 2'd1, 12'h444}));
    chk("t3_pending", 32'(pending), 32'h2);
    check_word("t3_first", {CMD, 2'd1, 12'h444}, 65, 1'b0);
    check_word("t3_resend", {CMD, 2'd1, 12'h666}, 68, 1'b1);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_pending_end", 32'(pending), 32'h0);

    // Write racing the LOAD of the same channel
    write(2'd0, 12'h777);
    tick();
    chk("t4_load", 32'(dbg_state), 32'(ST_LOAD));
    write(2'd0, 12'h999);
    chk("t4_dato", 32'(dac_dato), 32'({CMD, 2'd0, 12'h777}));
    chk("t4_pending", 32'(pending), 32'h1);
    check_word("t4_first", {CMD, 2'd0, 12'h777}, 68, 1'b0);
    check_word("t4_resend", {CMD, 2'd0, 12'h999}, 68, 1'b1);
    chk("t4_idle", 32'(busy), 32'd0);

    // Reset in the middle of XFER
    write(2'd3, 12'h123);
    tick(); tick();
    chk("t5_in_xfer", 32'(dac_ctrl), 32'd0);
    repeat (30) tick();
    write(2'd2, 12'h456);
    chk("t5_pending_pre", 32'(pending), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ctrl", 32'(dac_ctrl), 32'd1);
    chk("t5_pending", 32'(pending), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_upd_done", 32'(upd_done), 32'd0);
    chk("t5_dato", 32'(dac_dato), 32'h0);
    lo_cnt = 0; done_cnt = 0; busy_cnt = 0;
    repeat (100) begin
      tick();
      if (dac_ctrl !== 1'b1) lo_cnt++;
      if (upd_done !== 1'b0) done_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("t5_no_xfer", lo_cnt, 0);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_busy", busy_cnt, 0);

`ifdef DAC_SCHED_LDAC_SYNC_EN
    // Load-only words followed by a single shared LDAC strobe
    lows_snap = ldac_lows;
    write(2'd0, 12'hA5A);
    write(2'd3, 12'h5A5);
    check_word("t6_ch0", {2'b00, 2'd0, 12'hA5A}, 68, 1'b0);
    check_word("t6_ch3", {2'b00, 2'd3, 12'h5A5}, 68, 1'b1);
    repeat (5) tick();
    chk("t6_ldac_lows", ldac_lows - lows_snap, 2);
    chk("t6_ldac_end", 32'(ldac_n), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
`else
    lows_snap = 0;
    chk("ldac_const", ldac_lows - lows_snap, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
